rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Shares the single register-file write port between the pipeline writeback stage and a long-latency unit (LLU: multiplier/divider result path). Writeback always wins; LLU results are buffered in a 2-entry FIFO and drained on idle writeback cycles. A starvation counter asks the pipeline for a writeback bubble when the LLU has waited too long. An optional scoreboard tracks LLU destinations in flight for decode-stage RAW stalls.

## Interface
- STARVE_LIMIT, 4: consecutive denied cycles with FIFO non-empty before `arb_hold_ws` asserts (1..7)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- ws_we  in  4  writeback byte write enables (already gated by ws_valid); nonzero = request
- ws_waddr  in  5  writeback destination
- ws_wdata  in  32  writeback data
- llu_valid  in  1  LLU result valid
- llu_ready  out  1  FIFO can accept; equals !full
- llu_we  in  4  LLU byte enables
- llu_waddr  in  5  LLU destination
- llu_wdata  in  32  LLU data
- issue_valid  in  1  LLU op issued this cycle (scoreboard set)
- issue_dest  in  5  destination of issued LLU op
- ds_src1, ds_src2  in  5 each  decode source registers for busy query
- ds_busy  out  1  either source pending in scoreboard (combinational)
- arb_hold_ws  out  1  request upstream not to advance into WB next cycle
- rf_we  out  4  to RF write port
- rf_waddr  out  5  to RF
- rf_wdata  out  32  to RF

## Operation
- Grant (combinational): ws_we!=0 → WB drives rf_*; else FIFO non-empty → FIFO head drives rf_* and pops at edge; else rf_we=0, rf_waddr/rf_wdata=0.
- FIFO: 2 entries {we,waddr,wdata}, 1-bit wrap pointers plus count. Push when llu_valid && llu_ready. Pop when head granted. Push+pop same cycle allowed when count=1 (count stays 1); when full, llu_ready=0 regardless of pop (no same-cycle pass-through).
- No bypass: LLU result reaches RF no earlier than the cycle after its handshake.
- Starvation counter (3-bit): increments (saturating at 7) on each cycle FIFO non-empty and WB granted; clears when LLU granted or FIFO empty. arb_hold_ws = (count >= STARVE_LIMIT). If WB still requests while hold is high, WB still wins and counter holds/saturates.
- Writes to r0 pass through unchanged (RF discards).

## Timing
- Reset (async): FIFO empty, pointers 0, starvation count 0, scoreboard 0. While reset high: llu_ready=0, arb_hold_ws=0, ds_busy=0, rf_we=0. First cycle after release: llu_ready=1.
- rf_* combinational from ws_* and FIFO head; zero-cycle latency for WB.
- LLU latency: handshake edge N → earliest RF write at edge N+1 (rf_we visible in cycle after N).
- arb_hold_ws registered-derived: asserts cycle after counter reaches STARVE_LIMIT; deasserts cycle after LLU grant.
- Reset mid-operation: buffered LLU results and scoreboard bits discarded immediately.

## Configuration
- RF_ARB_SCOREBOARD_EN defined: 32-bit pending register; bit issue_dest set on issue_valid (never bit 0); bit cleared when LLU entry with that waddr is granted to RF; simultaneous set and clear of same bit → set wins. ds_busy = pend[ds_src1] | pend[ds_src2]. Issuing to an already-pending destination is illegal (decode stalls on busy).
- Not defined: no scoreboard state; ds_busy tied 0; issue_valid/issue_dest ignored.

## Test plan
- Reset, LLU push {we=F,waddr=5,wdata=0x1234} with WB idle → rf_we=F, rf_waddr=5, rf_wdata=0x1234 next cycle; FIFO empty after.
- WB writes r3=0xAAAA every cycle while LLU pushes r7, r8 → llu_ready=0 after second push; rf_* shows only r3; third llu_valid held until WB idles, then r7 then r8 in order.
- STARVE_LIMIT=4, FIFO non-empty, WB requests 4 consecutive cycles → arb_hold_ws=1 in 5th cycle; WB idles → LLU written, arb_hold_ws=0 next cycle.
- Count=1, WB idle, simultaneous push and pop → head written, new entry retained, llu_ready stays 1.
- Scoreboard build: issue r9, ds_src1=9 → ds_busy=1 until r9 LLU result granted, 0 the cycle after; issue r0 → ds_busy stays 0 for src 0.
- Assert reset with 2 entries buffered and r9 pending → llu_ready=0, rf_we=0, ds_busy=0 immediately; after release no stale writes.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: writeback always wins, LLU results wait in a 2-entry FIFO.
// Define RF_ARB_SCOREBOARD_EN to add the LLU-destination pending scoreboard (ds_busy).
module rf_wport_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ws_we,
    input  logic [4:0]  ws_waddr,
    input  logic [31:0] ws_wdata,
    input  logic        llu_valid,
    output logic        llu_ready,
    input  logic [3:0]  llu_we,
    input  logic [4:0]  llu_waddr,
    input  logic [31:0] llu_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  ds_src1,
    input  logic [4:0]  ds_src2,
    output logic        ds_busy,
    output logic        arb_hold_ws,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    typedef struct packed {
        logic [3:0]  we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } entry_t;

    localparam logic [2:0] STARVE_LIM3 = 3'(STARVE_LIMIT);

    entry_t     fifo_mem [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [2:0] starve_reg;

    entry_t head;
    logic   ws_req;
    logic   fifo_empty;
    logic   fifo_full;
    logic   push;
    logic   llu_grant;

    assign ws_req     = |ws_we;
    assign fifo_empty = (count_reg == 2'd0);
    assign fifo_full  = (count_reg == 2'd2);
    assign head       = fifo_mem[rd_ptr_reg];

    // No pass-through when full: a pop this cycle does not make room for a push.
    assign llu_ready  = !fifo_full && !reset;
    assign push       = llu_valid && llu_ready;
    assign llu_grant  = !ws_req && !fifo_empty && !reset;

    always_comb begin
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            if (ws_req) begin
                rf_we    = ws_we;
                rf_waddr = ws_waddr;
                rf_wdata = ws_wdata;
            end else if (!fifo_empty) begin
                rf_we    = head.we;
                rf_waddr = head.waddr;
                rf_wdata = head.wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (llu_grant)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(llu_grant);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {llu_we, llu_waddr, llu_wdata};
    end

    // A non-empty FIFO that is not granted means writeback took the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_reg <= 3'd0;
        else if (fifo_empty || llu_grant)
            starve_reg <= 3'd0;
        else if (starve_reg != 3'd7)
            starve_reg <= starve_reg + 3'd1;
    end

    assign arb_hold_ws = (starve_reg >= STARVE_LIM3);

`ifdef RF_ARB_SCOREBOARD_EN
    logic [31:0] pend_reg;
    logic [31:0] pend_next;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_r0
                assign pend_next[gi] = 1'b0;
            end else begin : g_rn
                // Set dominates a same-cycle clear of the same register.
                assign pend_next[gi] = (issue_valid && issue_dest == 5'(gi)) ||
                                       (pend_reg[gi] && !(llu_grant && head.waddr == 5'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend_reg <= '0;
        else
            pend_reg <= pend_next;
    end

    assign ds_busy = pend_reg[ds_src1] | pend_reg[ds_src2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_dest, ds_src1, ds_src2};
    assign ds_busy = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_rf_wport_arbiter;
    localparam int STARVE_LIMIT = 4;
`ifdef RF_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ws_we;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata;
    logic        llu_valid;
    logic        llu_ready;
    logic [3:0]  llu_we;
    logic [4:0]  llu_waddr;
    logic [31:0] llu_wdata;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [4:0]  ds_src1;
    logic [4:0]  ds_src2;
    logic        ds_busy;
    logic        arb_hold_ws;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [40:0] rf_all;

    int n_cmp = 0;
    int n_err = 0;

    assign rf_all = {rf_we, rf_waddr, rf_wdata};

    rf_wport_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ws_we(ws_we), .ws_waddr(ws_waddr), .ws_wdata(ws_wdata),
        .llu_valid(llu_valid), .llu_ready(llu_ready),
        .llu_we(llu_we), .llu_waddr(llu_waddr), .llu_wdata(llu_wdata),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_busy(ds_busy),
        .arb_hold_ws(arb_hold_ws),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    task automatic idle_inputs();
        ws_we = '0; ws_waddr = '0; ws_wdata = '0;
        llu_valid = 1'b0; llu_we = '0; llu_waddr = '0; llu_wdata = '0;
        issue_valid = 1'b0; issue_dest = '0; ds_src1 = '0; ds_src2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        ws_we = 4'hF; ws_waddr = 5'd3; ws_wdata = 32'h55; llu_valid = 1'b1;
        #2;
        n_cmp++;
        if ({llu_ready, arb_hold_ws, ds_busy, rf_we} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b hold=%b busy=%b rf_we=%h, required all zero",
                     llu_ready, arb_hold_ws, ds_busy, rf_we);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (llu_ready !== 1'b1 || rf_we !== 4'h0 || arb_hold_ws !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b rf_we=%h hold=%b, required 1/0/0",
                     llu_ready, rf_we, arb_hold_ws);
        end
        $display("reset: released");
        next_cycle();
    endtask

    task automatic test_llu_basic();
        idle_inputs();
        llu_valid = 1'b1; llu_we = 4'hF; llu_waddr = 5'd5; llu_wdata = 32'h1234;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 4'h0 || llu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL llu_no_bypass: got rf_we=%h ready=%b, required 0/1", rf_we, llu_ready);
        end
        next_cycle();
        llu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'hF, 5'd5, 32'h1234}) begin
            n_err++;
            $display("FAIL llu_write: got %h, required %h", rf_all, {4'hF, 5'd5, 32'h1234});
        end
        $display("llu: r5 <= %h", rf_wdata);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 4'h0 || llu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL llu_drained: got rf_we=%h ready=%b, required 0/1", rf_we, llu_ready);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [40:0] wb;
        idle_inputs();
        wb = {4'hF, 5'd3, 32'hAAAA};
        ws_we = 4'hF; ws_waddr = 5'd3; ws_wdata = 32'hAAAA;
        for (int c = 0; c < 4; c++) begin
            llu_valid = 1'b1; llu_we = 4'hF;
            llu_waddr = (c == 0) ? 5'd7 : (c == 1) ? 5'd8 : 5'd9;
            llu_wdata = (c == 0) ? 32'h7777 : (c == 1) ? 32'h8888 : 32'h9999;
            @(negedge clk);
            n_cmp++;
            if (rf_all !== wb || llu_ready !== (c < 2)) begin
                n_err++;
                $display("FAIL b2b_wb_cycle%0d: got rf=%h ready=%b, required rf=%h ready=%b",
                         c, rf_all, llu_ready, wb, (c < 2));
            end
            next_cycle();
        end
        ws_we = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'hF, 5'd7, 32'h7777} || llu_ready !== 1'b0 || arb_hold_ws !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_r7: got rf=%h ready=%b hold=%b, required r7 ready=0 hold=0",
                     rf_all, llu_ready, arb_hold_ws);
        end
        $display("b2b: r7 <= %h", rf_wdata);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'hF, 5'd8, 32'h8888} || llu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_r8: got rf=%h ready=%b, required r8 ready=1", rf_all, llu_ready);
        end
        $display("b2b: r8 <= %h", rf_wdata);
        next_cycle();
        llu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'hF, 5'd9, 32'h9999}) begin
            n_err++;
            $display("FAIL b2b_r9: got rf=%h, required %h", rf_all, {4'hF, 5'd9, 32'h9999});
        end
        $display("b2b: r9 <= %h", rf_wdata);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 4'h0) begin
            n_err++;
            $display("FAIL b2b_empty: got rf_we=%h, required 0", rf_we);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        idle_inputs();
        ws_we = 4'h3; ws_waddr = 5'd4; ws_wdata = 32'hBEEF;
        llu_valid = 1'b1; llu_we = 4'hC; llu_waddr = 5'd10; llu_wdata = 32'hA0A0;
        next_cycle();
        llu_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (arb_hold_ws !== (c == 5) || rf_we !== 4'h3) begin
                n_err++;
                $display("FAIL starve_cycle%0d: got hold=%b rf_we=%h, required hold=%b rf_we=3",
                         c, arb_hold_ws, rf_we, (c == 5));
            end
            next_cycle();
        end
        ws_we = 4'h0;
        @(negedge clk);
        n_cmp++;
        if (arb_hold_ws !== 1'b1 || rf_all !== {4'hC, 5'd10, 32'hA0A0}) begin
            n_err++;
            $display("FAIL starve_grant: got hold=%b rf=%h, required hold=1 rf=%h",
                     arb_hold_ws, rf_all, {4'hC, 5'd10, 32'hA0A0});
        end
        $display("starve: r10 <= %h after hold", rf_wdata);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (arb_hold_ws !== 1'b0 || rf_we !== 4'h0) begin
            n_err++;
            $display("FAIL starve_release: got hold=%b rf_we=%h, required 0/0", arb_hold_ws, rf_we);
        end
        next_cycle();
    endtask

    task automatic test_push_pop();
        idle_inputs();
        llu_valid = 1'b1; llu_we = 4'h1; llu_waddr = 5'd11; llu_wdata = 32'h1111;
        ws_we = 4'hF; ws_waddr = 5'd2;
        next_cycle();
        ws_we = 4'h0;
        llu_we = 4'h2; llu_waddr = 5'd12; llu_wdata = 32'h2222;
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'h1, 5'd11, 32'h1111} || llu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pushpop_head: got rf=%h ready=%b, required r11 ready=1", rf_all, llu_ready);
        end
        next_cycle();
        llu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'h2, 5'd12, 32'h2222} || llu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pushpop_kept: got rf=%h ready=%b, required r12 ready=1", rf_all, llu_ready);
        end
        $display("pushpop: r11 then r12 written");
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 4'h0) begin
            n_err++;
            $display("FAIL pushpop_empty: got rf_we=%h, required 0", rf_we);
        end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        issue_valid = 1'b1; issue_dest = 5'd9; ds_src1 = 5'd9;
        @(negedge clk);
        n_cmp++;
        if (ds_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_before_issue: got busy=%b, required 0", ds_busy);
        end
        next_cycle();
        issue_dest = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (ds_busy !== SB_EN) begin
            n_err++;
            $display("FAIL sb_pending: got busy=%b, required %b", ds_busy, SB_EN);
        end
        next_cycle();
        issue_valid = 1'b0; ds_src1 = 5'd0; ds_src2 = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (ds_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_r0: got busy=%b, required 0", ds_busy);
        end
        ds_src2 = 5'd9;
        #1;
        n_cmp++;
        if (ds_busy !== SB_EN) begin
            n_err++;
            $display("FAIL sb_src2: got busy=%b, required %b", ds_busy, SB_EN);
        end
        next_cycle();
        ws_we = 4'hF; ws_waddr = 5'd3;
        llu_valid = 1'b1; llu_we = 4'hF; llu_waddr = 5'd9; llu_wdata = 32'h99;
        next_cycle();
        ws_we = 4'h0; llu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rf_all !== {4'hF, 5'd9, 32'h99} || ds_busy !== SB_EN) begin
            n_err++;
            $display("FAIL sb_grant: got rf=%h busy=%b, required r9 busy=%b", rf_all, ds_busy, SB_EN);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (ds_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_cleared: got busy=%b, required 0", ds_busy);
        end
        $display("scoreboard: r9 issued and retired");
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ws_we = 4'hF; ws_waddr = 5'd3; ws_wdata = 32'hAAAA;
        llu_valid = 1'b1; llu_we = 4'hF; llu_waddr = 5'd9; llu_wdata = 32'h9999;
        issue_valid = 1'b1; issue_dest = 5'd9; ds_src1 = 5'd9;
        next_cycle();
        issue_valid = 1'b0; llu_waddr = 5'd10;
        next_cycle();
        llu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (llu_ready !== 1'b0 || ds_busy !== SB_EN) begin
            n_err++;
            $display("FAIL midrst_setup: got ready=%b busy=%b, required 0/%b", llu_ready, ds_busy, SB_EN);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({llu_ready, rf_we, ds_busy, arb_hold_ws} !== 7'b0) begin
            n_err++;
            $display("FAIL midrst_assert: got ready=%b rf_we=%h busy=%b hold=%b, required all zero",
                     llu_ready, rf_we, ds_busy, arb_hold_ws);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        ds_src1 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_we !== 4'h0 || llu_ready !== 1'b1 || ds_busy !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_after%0d: got rf_we=%h ready=%b busy=%b, required 0/1/0",
                         c, rf_we, llu_ready, ds_busy);
            end
            next_cycle();
        end
        $display("midrst: buffered entries discarded");
    endtask

    task automatic test_random(input int ncyc);
        ent_t        mq[$];
        ent_t        e;
        int          m_starve;
        int          sz0;
        bit [31:0]   m_pend;
        logic [40:0] exp_rf;
        bit          exp_ready, exp_hold, exp_busy, llu_wins;
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        reset = 1'b0;
        m_starve = 0;
        m_pend = '0;
        for (int c = 0; c < ncyc; c++) begin
            exp_hold = (m_starve >= STARVE_LIMIT);
            ws_we = ($urandom_range(0, 99) < (exp_hold ? 30 : 65)) ? 4'($urandom_range(1, 15)) : 4'h0;
            ws_waddr = 5'($urandom); ws_wdata = $urandom;
            llu_valid = 1'($urandom_range(0, 1));
            llu_we = 4'($urandom); llu_waddr = 5'($urandom); llu_wdata = $urandom;
            issue_dest = 5'($urandom);
            issue_valid = ($urandom_range(0, 3) == 0) && !m_pend[issue_dest];
            ds_src1 = 5'($urandom); ds_src2 = 5'($urandom);

            sz0 = mq.size();
            exp_ready = (sz0 < 2);
            llu_wins = (ws_we == 4'h0) && (sz0 > 0);
            if (ws_we != 4'h0)
                exp_rf = {ws_we, ws_waddr, ws_wdata};
            else if (llu_wins)
                exp_rf = {mq[0].we, mq[0].a, mq[0].d};
            else
                exp_rf = '0;
            exp_busy = SB_EN && (m_pend[ds_src1] || m_pend[ds_src2]);

            @(negedge clk);
            n_cmp++;
            if (rf_all !== exp_rf) begin
                n_err++;
                $display("FAIL rand_rf cyc%0d: got %h, required %h", c, rf_all, exp_rf);
            end
            n_cmp++;
            if (llu_ready !== exp_ready) begin
                n_err++;
                $display("FAIL rand_ready cyc%0d: got %b, required %b", c, llu_ready, exp_ready);
            end
            n_cmp++;
            if (arb_hold_ws !== exp_hold) begin
                n_err++;
                $display("FAIL rand_hold cyc%0d: got %b, required %b", c, arb_hold_ws, exp_hold);
            end
            n_cmp++;
            if (ds_busy !== exp_busy) begin
                n_err++;
                $display("FAIL rand_busy cyc%0d: got %b, required %b", c, ds_busy, exp_busy);
            end

            if (llu_wins) begin
                e = mq.pop_front();
                m_pend[e.a] = 1'b0;
                $display("rand cyc%0d: llu r%0d <= %h", c, e.a, e.d);
            end
            if (issue_valid && issue_dest != 5'd0)
                m_pend[issue_dest] = 1'b1;
            if (llu_valid && exp_ready)
                mq.push_back('{llu_we, llu_waddr, llu_wdata});
            if (sz0 > 0 && ws_we != 4'h0)
                m_starve = (m_starve < 7) ? m_starve + 1 : 7;
            else
                m_starve = 0;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_llu_basic();
        test_back_to_back();
        test_starvation();
        test_push_pop();
        test_scoreboard();
        test_reset_mid();
        test_random(500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
